// File: rtl/gpu_line_pkg.sv
// Shared types and geometry for the line-draw scheduler: command word, FSM states,
// framebuffer dimensions and the on-screen test used by the optional clipping path.
package gpu_line_pkg;

    localparam int WIDTH_BITS   = 10;
    localparam int HEIGHT_BITS  = 9;
    localparam int CHANNEL_BITS = 8;
    localparam int COLOR_BITS   = 3 * CHANNEL_BITS;

    localparam int WIDTH  = 640;
    localparam int HEIGHT = 480;

    localparam int FIFO_DEPTH_DEFAULT = 4;
    localparam int TIMEOUT_DEFAULT    = 8;

    typedef struct packed {
        logic [WIDTH_BITS-1:0]  x1;
        logic [HEIGHT_BITS-1:0] y1;
        logic [WIDTH_BITS-1:0]  x2;
        logic [HEIGHT_BITS-1:0] y2;
        logic [COLOR_BITS-1:0]  color;
    } line_cmd_t;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN,
        GAP
    } sched_state_t;

    function automatic logic pix_in_bounds(input logic [WIDTH_BITS-1:0]  x,
                                           input logic [HEIGHT_BITS-1:0] y);
        return (int'(x) < WIDTH) && (int'(y) < HEIGHT);
    endfunction

endpackage

// File: rtl/gpu_cmd_fifo.sv
// Synchronous command FIFO with registered full/empty flags and a single-cycle flush.
// Flush wins over push and pop in the same cycle.
module gpu_cmd_fifo
    import gpu_line_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH_DEFAULT
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      push,
    input  logic      pop,
    input  logic      flush,
    input  line_cmd_t wr_data,
    output line_cmd_t rd_data,
    output logic      full,
    output logic      empty
);

    localparam int AW = $clog2(DEPTH);

    line_cmd_t       mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     count;
    logic [AW:0]     count_next;
    logic            do_push;
    logic            do_pop;

    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;

    always_comb begin
        count_next = count;
        if (flush) begin
            count_next = '0;
        end else if (do_push && !do_pop) begin
            count_next = count + 1'b1;
        end else if (!do_push && do_pop) begin
            count_next = count - 1'b1;
        end
    end

    // Flags are registered from the next count so cmd_ready comes straight off a flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (do_push) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (do_pop) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
            end
            count <= count_next;
            full  <= (count_next == (AW+1)'(DEPTH));
            empty <= (count_next == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/gpu_line_sched.sv
// Line-draw scheduler: queues commands, sequences the line engine one line at a time and
// tags each stepped pixel with the line colour. Define GPU_LINE_CLIP_EN to drop off-screen pixels.
module gpu_line_sched
    import gpu_line_pkg::*;
#(
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEFAULT,
    parameter int TIMEOUT    = TIMEOUT_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [WIDTH_BITS-1:0]  cmd_x1,
    input  logic [HEIGHT_BITS-1:0] cmd_y1,
    input  logic [WIDTH_BITS-1:0]  cmd_x2,
    input  logic [HEIGHT_BITS-1:0] cmd_y2,
    input  logic [COLOR_BITS-1:0]  cmd_color,
    input  logic                   abort,
    output logic [WIDTH_BITS-1:0]  eng_x1,
    output logic [HEIGHT_BITS-1:0] eng_y1,
    output logic [WIDTH_BITS-1:0]  eng_x2,
    output logic [HEIGHT_BITS-1:0] eng_y2,
    output logic                   eng_start,
    input  logic                   eng_busy,
    input  logic                   eng_done,
    input  logic [WIDTH_BITS-1:0]  eng_X,
    input  logic [HEIGHT_BITS-1:0] eng_Y,
    output logic                   pix_valid,
    output logic [WIDTH_BITS-1:0]  pix_x,
    output logic [HEIGHT_BITS-1:0] pix_y,
    output logic [COLOR_BITS-1:0]  pix_color,
    output logic                   idle,
    output logic                   err,
    output logic [15:0]            line_count
);

    localparam int                TMO_W    = $clog2(TIMEOUT + 1);
    localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TIMEOUT - 1);

    sched_state_t           state;
    sched_state_t           state_next;
    line_cmd_t              cmd_word;
    line_cmd_t              head;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   load_cmd;
    logic                   line_done;
    logic                   tmo_hit;
    logic                   capture;
    logic                   pix_fire;
    logic [COLOR_BITS-1:0]  color_q;
    logic [TMO_W-1:0]       tmo_cnt;
    logic                   seen_busy;

    logic                   pix_vld_p1;
    logic [WIDTH_BITS-1:0]  pix_x_p1;
    logic [HEIGHT_BITS-1:0] pix_y_p1;
    logic [COLOR_BITS-1:0]  pix_color_p1;

    assign cmd_word = '{x1: cmd_x1, y1: cmd_y1, x2: cmd_x2, y2: cmd_y2, color: cmd_color};

    gpu_cmd_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (cmd_valid && cmd_ready),
        .pop     (load_cmd),
        .flush   (abort),
        .wr_data (cmd_word),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign cmd_ready = !fifo_full;
    assign eng_start = (state == RUN);
    assign idle      = fifo_empty && (state == IDLE);

    always_comb begin
        state_next = state;
        load_cmd   = 1'b0;
        line_done  = 1'b0;
        tmo_hit    = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    state_next = LOAD;
                    load_cmd   = 1'b1;
                end
            end
            LOAD: state_next = RUN;
            RUN: begin
                if (eng_done) begin
                    state_next = GAP;
                    line_done  = 1'b1;
                end else if (!seen_busy && !eng_busy && tmo_cnt == TMO_LAST) begin
                    state_next = GAP;
                    tmo_hit    = 1'b1;
                end
            end
            GAP:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
        // GAP after an abort still gives the engine a low start before any new line.
        if (abort) begin
            state_next = GAP;
            load_cmd   = 1'b0;
            line_done  = 1'b0;
            tmo_hit    = 1'b0;
        end
    end

    assign capture = (state == RUN) && eng_busy && !abort;

`ifdef GPU_LINE_CLIP_EN
    assign pix_fire = capture && pix_in_bounds(eng_X, eng_Y);
`else
    assign pix_fire = capture;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            eng_x1     <= '0;
            eng_y1     <= '0;
            eng_x2     <= '0;
            eng_y2     <= '0;
            color_q    <= '0;
            tmo_cnt    <= '0;
            seen_busy  <= 1'b0;
            err        <= 1'b0;
            line_count <= '0;
        end else begin
            state <= state_next;
            if (load_cmd) begin
                eng_x1  <= head.x1;
                eng_y1  <= head.y1;
                eng_x2  <= head.x2;
                eng_y2  <= head.y2;
                color_q <= head.color;
            end
            // Timeout only counts while the engine has not yet shown any activity on this line.
            if (state == RUN) begin
                if (eng_busy) begin
                    seen_busy <= 1'b1;
                end else if (!seen_busy) begin
                    tmo_cnt <= tmo_cnt + 1'b1;
                end
            end else begin
                tmo_cnt   <= '0;
                seen_busy <= 1'b0;
            end
            if (tmo_hit) begin
                err <= 1'b1;
            end
            if (line_done) begin
                line_count <= line_count + 16'd1;
            end
        end
    end

    // Stage p1: engine pixel registered and tagged with the line colour.
    always_ff @(posedge clk) begin
        if (rst) begin
            pix_vld_p1   <= 1'b0;
            pix_x_p1     <= '0;
            pix_y_p1     <= '0;
            pix_color_p1 <= '0;
        end else begin
            pix_vld_p1 <= pix_fire;
            if (capture) begin
                pix_x_p1     <= eng_X;
                pix_y_p1     <= eng_Y;
                pix_color_p1 <= color_q;
            end
        end
    end

    assign pix_valid = pix_vld_p1;
    assign pix_x     = pix_x_p1;
    assign pix_y     = pix_y_p1;
    assign pix_color = pix_color_p1;

endmodule

// File: tb/tb_gpu_line_sched.sv
// Bench for gpu_line_sched: a behavioural Bresenham engine drives the handshake, and a
// scoreboard of expected pixels (derived from pushed commands) is checked every cycle.
`timescale 1ns/1ps
module tb_gpu_line_sched;
    import gpu_line_pkg::*;

    localparam int W = WIDTH_BITS;
    localparam int H = HEIGHT_BITS;
    localparam int C = COLOR_BITS;
`ifdef GPU_LINE_CLIP_EN
    localparam int CLIP_PIX = 2;
`else
    localparam int CLIP_PIX = 4;
`endif

    typedef struct packed {
        logic [W-1:0] x;
        logic [H-1:0] y;
        logic [C-1:0] c;
    } pix_t;
    typedef pix_t pix_q_t[$];

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         cmd_valid = 1'b0;
    logic         cmd_ready;
    logic [W-1:0] cmd_x1 = '0;
    logic [H-1:0] cmd_y1 = '0;
    logic [W-1:0] cmd_x2 = '0;
    logic [H-1:0] cmd_y2 = '0;
    logic [C-1:0] cmd_color = '0;
    logic         abort = 1'b0;
    logic [W-1:0] eng_x1;
    logic [H-1:0] eng_y1;
    logic [W-1:0] eng_x2;
    logic [H-1:0] eng_y2;
    logic         eng_start;
    logic         eng_busy = 1'b0;
    logic         eng_done = 1'b0;
    logic [W-1:0] eng_X = '0;
    logic [H-1:0] eng_Y = '0;
    logic         pix_valid;
    logic [W-1:0] pix_x;
    logic [H-1:0] pix_y;
    logic [C-1:0] pix_color;
    logic         idle;
    logic         err;
    logic [15:0]  line_count;

    int   n_tests = 0;
    int   n_fail  = 0;
    pix_t exp_q[$];
    pix_t obs_q[$];
    bit   eng_mute = 1'b0;
    pix_t eng_q[$];
    pix_t eng_p;
    logic start_q = 1'b0;

    always #5 clk = ~clk;

    gpu_line_sched #(.FIFO_DEPTH(4), .TIMEOUT(8)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_x1(cmd_x1), .cmd_y1(cmd_y1), .cmd_x2(cmd_x2), .cmd_y2(cmd_y2),
        .cmd_color(cmd_color), .abort(abort),
        .eng_x1(eng_x1), .eng_y1(eng_y1), .eng_x2(eng_x2), .eng_y2(eng_y2),
        .eng_start(eng_start), .eng_busy(eng_busy), .eng_done(eng_done),
        .eng_X(eng_X), .eng_Y(eng_Y),
        .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y), .pix_color(pix_color),
        .idle(idle), .err(err), .line_count(line_count)
    );

    // All points of a line in drawing order, endpoints included.
    function automatic pix_q_t line_pts(input int x1, input int y1, input int x2, input int y2,
                                        input logic [C-1:0] c);
        pix_q_t q;
        pix_t   p;
        int dx, dy, sx, sy, e, e2, x, y;
        dx = (x2 > x1) ? x2 - x1 : x1 - x2;
        dy = (y2 > y1) ? y1 - y2 : y2 - y1;
        sx = (x1 < x2) ? 1 : -1;
        sy = (y1 < y2) ? 1 : -1;
        e  = dx + dy;
        x  = x1;
        y  = y1;
        for (int k = 0; k < 4096; k++) begin
            p.x = W'(x);
            p.y = H'(y);
            p.c = c;
            q.push_back(p);
            if (x == x2 && y == y2) break;
            e2 = 2 * e;
            if (e2 >= dy) begin e += dy; x += sx; end
            if (e2 <= dx) begin e += dx; y += sy; end
        end
        return q;
    endfunction

    function automatic bit visible(input pix_t p);
`ifdef GPU_LINE_CLIP_EN
        return (int'(p.x) < WIDTH) && (int'(p.y) < HEIGHT);
`else
        return 1'b1;
`endif
    endfunction

    // Engine model: on a rising start, step one point per cycle with busy, then pulse done.
    initial begin
        forever begin
            @(posedge clk);
            if (rst || !eng_start) begin
                eng_busy <= 1'b0;
                eng_done <= 1'b0;
                eng_q.delete();
            end else if (!start_q) begin
                if (!eng_mute) begin
                    eng_q = line_pts(int'(eng_x1), int'(eng_y1), int'(eng_x2), int'(eng_y2), {C{1'b0}});
                    eng_p = eng_q.pop_front();
                    eng_X    <= eng_p.x;
                    eng_Y    <= eng_p.y;
                    eng_busy <= 1'b1;
                end
            end else if (eng_busy) begin
                if (eng_q.size() > 0) begin
                    eng_p = eng_q.pop_front();
                    eng_X <= eng_p.x;
                    eng_Y <= eng_p.y;
                end else begin
                    eng_busy <= 1'b0;
                    eng_done <= 1'b1;
                end
            end else begin
                eng_done <= 1'b0;
            end
            start_q <= eng_start;
        end
    end

    // Pixel scoreboard.
    initial begin
        pix_t got;
        pix_t want;
        forever begin
            @(negedge clk);
            if (pix_valid) begin
                got = '{x: pix_x, y: pix_y, c: pix_color};
                obs_q.push_back(got);
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL pixel got=(%0d,%0d,%06h) required=no pixel", pix_x, pix_y, pix_color);
                end else begin
                    want = exp_q.pop_front();
                    if (got !== want) begin
                        n_fail++;
                        $display("FAIL pixel got=(%0d,%0d,%06h) required=(%0d,%0d,%06h)",
                                 got.x, got.y, got.c, want.x, want.y, want.c);
                    end
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog got=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int got, input int req);
        n_tests++;
        if (got !== req) begin
            n_fail++;
            $display("FAIL %s got=%0d required=%0d", name, got, req);
        end
    endtask

    task automatic bound_fail(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s got=timeout required=event", name);
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        cmd_valid = 1'b0;
        abort     = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic push_cmd(input int x1, input int y1, input int x2, input int y2,
                            input logic [C-1:0] c, input bit add_exp);
        pix_q_t pts;
        bit rdy;
        bit acc;
        if (add_exp) begin
            pts = line_pts(x1, y1, x2, y2, c);
            foreach (pts[i]) if (visible(pts[i])) exp_q.push_back(pts[i]);
        end
        cmd_x1    = W'(x1);
        cmd_y1    = H'(y1);
        cmd_x2    = W'(x2);
        cmd_y2    = H'(y2);
        cmd_color = c;
        cmd_valid = 1'b1;
        acc = 1'b0;
        for (int i = 0; i < 400 && !acc; i++) begin
            rdy = cmd_ready;
            @(posedge clk);
            #1;
            acc = rdy;
        end
        cmd_valid = 1'b0;
        if (!acc) bound_fail("push_accept");
    endtask

    task automatic wait_drain(input string name, input int bound);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < bound && !ok; i++) begin
            @(posedge clk);
            #1;
            ok = idle && (exp_q.size() == 0);
        end
        if (!ok) bound_fail(name);
    endtask

    initial begin
        pix_q_t pts;
        int ex [4] = '{0, 1, 2, 3};
        int ey [4] = '{0, 0, 1, 1};
        int n_run;
        bit ok;

        // Reset state
        do_reset();
        check("rst_idle", int'(idle), 1);
        check("rst_cmd_ready", int'(cmd_ready), 1);
        check("rst_eng_start", int'(eng_start), 0);
        check("rst_pix_valid", int'(pix_valid), 0);
        check("rst_err", int'(err), 0);
        check("rst_line_count", int'(line_count), 0);
        check("rst_eng_x2", int'(eng_x2), 0);

        // Pin the line model against hand-worked points
        pts = line_pts(0, 0, 3, 1, 24'hFF0000);
        check("model_len", pts.size(), 4);
        for (int i = 0; i < 4 && i < pts.size(); i++) begin
            check("model_x", int'(pts[i].x), ex[i]);
            check("model_y", int'(pts[i].y), ey[i]);
        end

        // 1: shallow line
        push_cmd(0, 0, 3, 1, 24'hFF0000, 1'b1);
        wait_drain("t1_drain", 100);
        check("t1_npix", obs_q.size(), 4);
        for (int i = 0; i < 4 && i < obs_q.size(); i++) begin
            check("t1_x", int'(obs_q[i].x), ex[i]);
            check("t1_y", int'(obs_q[i].y), ey[i]);
            check("t1_color", int'(obs_q[i].c), 32'hFF0000);
        end
        check("t1_line_count", int'(line_count), 1);
        check("t1_idle", int'(idle), 1);

        // 2: degenerate line
        do_reset();
        push_cmd(5, 5, 5, 5, 24'h00FF00, 1'b1);
        wait_drain("t2_drain", 100);
        check("t2_npix", obs_q.size(), 1);
        if (obs_q.size() > 0) begin
            check("t2_x", int'(obs_q[0].x), 5);
            check("t2_y", int'(obs_q[0].y), 5);
        end
        check("t2_line_count", int'(line_count), 1);

        // 3: fill the queue behind a running line
        do_reset();
        push_cmd(0, 0, 20, 0, 24'h123456, 1'b1);
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            if (eng_start) ok = 1'b1;
            else begin @(posedge clk); #1; end
        end
        if (!ok) bound_fail("t3_start");
        push_cmd(1, 1, 4, 2, 24'h0000FF, 1'b1);
        push_cmd(10, 3, 7, 9, 24'hABCDEF, 1'b1);
        check("t3_ready_before_full", int'(cmd_ready), 1);
        push_cmd(2, 8, 2, 4, 24'h777777, 1'b1);
        push_cmd(0, 0, 6, 6, 24'h010203, 1'b1);
        check("t3_ready_full", int'(cmd_ready), 0);
        push_cmd(9, 9, 3, 7, 24'hC0FFEE, 1'b1);
        wait_drain("t3_drain", 800);
        check("t3_line_count", int'(line_count), 6);

        // 4: abort mid-line with two commands queued
        do_reset();
        push_cmd(0, 0, 0, 9, 24'hAA0000, 1'b1);
        push_cmd(3, 3, 5, 3, 24'h00AA00, 1'b1);
        push_cmd(1, 2, 3, 4, 24'h0000AA, 1'b1);
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            ok = pix_valid;
        end
        if (!ok) bound_fail("t4_first_pix");
        abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        exp_q.delete();
        check("t4_pix_valid", int'(pix_valid), 0);
        check("t4_eng_start", int'(eng_start), 0);
        check("t4_line_count", int'(line_count), 0);
        ok = 1'b0;
        for (int i = 0; i < 2 && !ok; i++) begin
            @(posedge clk);
            #1;
            ok = idle;
        end
        if (!ok) bound_fail("t4_idle");
        repeat (10) @(posedge clk);
        #1;
        check("t4_idle_hold", int'(idle), 1);
        check("t4_line_count_hold", int'(line_count), 0);
        check("t4_npix", obs_q.size(), 1);

        // 5: engine never goes busy
        do_reset();
        eng_mute = 1'b1;
        push_cmd(2, 2, 4, 4, 24'h111111, 1'b0);
        n_run = 0;
        ok = 1'b0;
        for (int i = 0; i < 60 && !ok; i++) begin
            if (err) ok = 1'b1;
            else begin
                if (eng_start) n_run++;
                @(posedge clk);
                #1;
            end
        end
        if (!ok) bound_fail("t5_err");
        check("t5_run_cycles", n_run, 8);
        wait_drain("t5_idle", 10);
        check("t5_line_count", int'(line_count), 0);
        repeat (5) @(posedge clk);
        #1;
        check("t5_err_sticky", int'(err), 1);
        eng_mute = 1'b0;
        do_reset();
        check("t5_err_cleared", int'(err), 0);

        // 6: line crossing the right edge
        do_reset();
        push_cmd(WIDTH - 2, 0, WIDTH + 1, 0, 24'h00FFFF, 1'b1);
        wait_drain("t6_drain", 100);
        check("t6_npix", obs_q.size(), CLIP_PIX);
        check("t6_line_count", int'(line_count), 1);

        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
